hex_scan_driver: RTL and testbench



---
 rtl/hex_disp_pkg.sv | 28 ++
 rtl/hex_seg_decode.sv | 33 +++
 rtl/hex_scan_driver.sv | 128 ++++++++++++
 tb/tb_hex_scan_driver.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/hex_disp_pkg.sv
// Shared constants for the hex scan display: active-low 7-segment patterns
// (bit order g..a), the blank pattern, and the index-width helper.
package hex_disp_pkg;

  localparam logic [6:0] SEG_HEX_0 = 7'h40;
  localparam logic [6:0] SEG_HEX_1 = 7'h79;
  localparam logic [6:0] SEG_HEX_2 = 7'h24;
  localparam logic [6:0] SEG_HEX_3 = 7'h30;
  localparam logic [6:0] SEG_HEX_4 = 7'h19;
  localparam logic [6:0] SEG_HEX_5 = 7'h12;
  localparam logic [6:0] SEG_HEX_6 = 7'h02;
  localparam logic [6:0] SEG_HEX_7 = 7'h78;
  localparam logic [6:0] SEG_HEX_8 = 7'h00;
  localparam logic [6:0] SEG_HEX_9 = 7'h18;
  localparam logic [6:0] SEG_HEX_A = 7'h08;
  localparam logic [6:0] SEG_HEX_B = 7'h03;
  localparam logic [6:0] SEG_HEX_C = 7'h46;
  localparam logic [6:0] SEG_HEX_D = 7'h21;
  localparam logic [6:0] SEG_HEX_E = 7'h06;
  localparam logic [6:0] SEG_HEX_F = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational nibble to active-low 7-segment pattern mapper (g..a).
module hex_seg_decode
  import hex_disp_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nibble)
      4'h0: o_seg = SEG_HEX_0;
      4'h1: o_seg = SEG_HEX_1;
      4'h2: o_seg = SEG_HEX_2;
      4'h3: o_seg = SEG_HEX_3;
      4'h4: o_seg = SEG_HEX_4;
      4'h5: o_seg = SEG_HEX_5;
      4'h6: o_seg = SEG_HEX_6;
      4'h7: o_seg = SEG_HEX_7;
      4'h8: o_seg = SEG_HEX_8;
      4'h9: o_seg = SEG_HEX_9;
      4'hA: o_seg = SEG_HEX_A;
      4'hB: o_seg = SEG_HEX_B;
      4'hC: o_seg = SEG_HEX_C;
      4'hD: o_seg = SEG_HEX_D;
      4'hE: o_seg = SEG_HEX_E;
      4'hF: o_seg = SEG_HEX_F;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hex_scan_driver.sv
// Multiplexed hex display scanner with frame-synchronous shadow loading.
// Optional blink support is compiled in with macro HEX_SCAN_BLINK_EN.
module hex_scan_driver
  import hex_disp_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int LZ_BLANK     = 0,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic [NUM_DIGITS-1:0]   blink,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_start
);

  localparam int IW = idx_width(NUM_DIGITS);
  localparam int PW = idx_width(SCAN_DIV);
  localparam int VW = 4 * NUM_DIGITS;

  logic [PW-1:0]         r_presc;
  logic [IW-1:0]         r_idx;
  logic [VW-1:0]         r_sh_val, r_disp_val;
  logic [NUM_DIGITS-1:0] r_sh_dp, r_disp_dp;
  logic                  r_loaded, r_valid;
  logic [7:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_digit_en;
  logic                  r_frame_start;

  logic                  w_tick, w_wrap, w_valid_nxt, w_lz, w_blink_off;
  logic [IW-1:0]         w_idx_nxt;
  logic [VW-1:0]         w_disp_val_nxt;
  logic [NUM_DIGITS-1:0] w_disp_dp_nxt;
  logic [3:0]            w_nib;
  logic [6:0]            w_pat;
  logic [7:0]            w_seg_nxt;

  assign w_tick    = (r_presc == PW'(SCAN_DIV - 1));
  assign w_wrap    = w_tick && (r_idx == IW'(NUM_DIGITS - 1));
  assign w_idx_nxt = !w_tick ? r_idx : (w_wrap ? '0 : r_idx + 1'b1);

  // A load on the boundary edge bypasses the shadow so it shows this frame.
  assign w_disp_val_nxt = !w_wrap ? r_disp_val : (load ? value : r_sh_val);
  assign w_disp_dp_nxt  = !w_wrap ? r_disp_dp  : (load ? dp    : r_sh_dp);
  assign w_valid_nxt    = r_valid || (w_wrap && (load || r_loaded));

  // Outputs are built from next-state values so they track the new index one cycle after the tick.
  assign w_nib = w_disp_val_nxt[{w_idx_nxt, 2'b00} +: 4];
  assign w_lz  = (LZ_BLANK != 0) && (w_idx_nxt != '0) &&
                 ((w_disp_val_nxt >> {w_idx_nxt, 2'b00}) == '0);

  hex_seg_decode u_seg_decode (
    .i_nibble (w_nib),
    .o_seg    (w_pat)
  );

`ifdef HEX_SCAN_BLINK_EN
  localparam int BW = idx_width(BLINK_FRAMES);
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_phase;
  logic          w_blink_last, w_blink_phase_nxt;

  assign w_blink_last      = (r_blink_cnt == BW'(BLINK_FRAMES - 1));
  assign w_blink_phase_nxt = (w_wrap && w_blink_last) ? ~r_blink_phase : r_blink_phase;
  assign w_blink_off       = w_blink_phase_nxt && blink[w_idx_nxt];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (w_wrap) begin
      r_blink_cnt   <= w_blink_last ? '0 : r_blink_cnt + 1'b1;
      r_blink_phase <= w_blink_phase_nxt;
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (^blink) ^ (BLINK_FRAMES > 0);
  assign w_blink_off  = 1'b0;
`endif

  always_comb begin
    w_seg_nxt = 8'hFF;
    if (w_valid_nxt && !w_blink_off)
      w_seg_nxt = {~w_disp_dp_nxt[w_idx_nxt], (w_lz ? SEG_BLANK : w_pat)};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_presc       <= '0;
      r_idx         <= '0;
      r_sh_val      <= '0;
      r_sh_dp       <= '0;
      r_disp_val    <= '0;
      r_disp_dp     <= '0;
      r_loaded      <= 1'b0;
      r_valid       <= 1'b0;
      r_seg         <= 8'hFF;
      r_digit_en    <= '1;
      r_frame_start <= 1'b0;
    end else begin
      r_presc       <= w_tick ? '0 : r_presc + 1'b1;
      r_idx         <= w_idx_nxt;
      if (load) begin
        r_sh_val <= value;
        r_sh_dp  <= dp;
        r_loaded <= 1'b1;
      end
      r_disp_val    <= w_disp_val_nxt;
      r_disp_dp     <= w_disp_dp_nxt;
      r_valid       <= w_valid_nxt;
      r_seg         <= w_seg_nxt;
      r_digit_en    <= ~(NUM_DIGITS'(1) << w_idx_nxt);
      r_frame_start <= w_wrap;
    end
  end

  assign seg         = r_seg;
  assign digit_en    = r_digit_en;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Self-checking bench for hex_scan_driver: a plain and a leading-zero-blanking
// instance share stimulus and are compared against a frame-level model.
module tb_hex_scan_driver;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int FRAME = SD * ND;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blink = '0;
  logic [7:0]  seg0, seg1;
  logic [3:0]  en0, en1;
  logic        fs0, fs1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hex_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .LZ_BLANK(0), .BLINK_FRAMES(BF)) u_dut (
    .clk(clk), .resetn(resetn), .load(load), .value(value), .dp(dp), .blink(blink),
    .seg(seg0), .digit_en(en0), .frame_start(fs0)
  );

  hex_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .LZ_BLANK(1), .BLINK_FRAMES(BF)) u_dut_lz (
    .clk(clk), .resetn(resetn), .load(load), .value(value), .dp(dp), .blink(blink),
    .seg(seg1), .digit_en(en1), .frame_start(fs1)
  );

  logic [6:0] hex_pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: time since release, pending shadow, displayed frame contents.
  int          m_t = 0;
  int          m_frames = 0;
  bit          m_loaded = 0, m_valid = 0;
  logic [15:0] m_sh_val = '0, m_disp_val = '0;
  logic [3:0]  m_sh_dp = '0, m_disp_dp = '0;
  logic [3:0]  cur_blink = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_seg(input bit lz, input int idx, input logic [3:0] bl);
    logic [3:0] nib;
    if (!m_valid) return 8'hFF;
`ifdef HEX_SCAN_BLINK_EN
    if (((m_frames / BF) % 2) == 1 && bl[idx]) return 8'hFF;
`else
    if (bl === 4'bxxxx) return 8'hFF;
`endif
    nib = m_disp_val[idx*4 +: 4];
    if (lz && idx != 0 && (m_disp_val >> (idx*4)) == 16'h0) return {~m_disp_dp[idx], 7'h7F};
    return {~m_disp_dp[idx], hex_pat[nib]};
  endfunction

  // One clock edge: drive on negedge, update the model, compare #1 after posedge.
  task automatic step(input bit ld, input logic [15:0] v, input logic [3:0] d, input bit rst);
    int idx;
    @(negedge clk);
    load = ld; value = v; dp = d; blink = cur_blink; resetn = ~rst;
    @(posedge clk);
    #1;
    if (rst) begin
      m_t = 0; m_frames = 0; m_loaded = 0; m_valid = 0;
      m_sh_val = '0; m_sh_dp = '0; m_disp_val = '0; m_disp_dp = '0;
      check("rst_seg", seg0, 8'hFF);
      check("rst_en", en0, 4'hF);
      check("rst_fs", fs0, 0);
      check("rst_seg_lz", seg1, 8'hFF);
    end else begin
      m_t++;
      if (ld) begin
        m_sh_val = v; m_sh_dp = d; m_loaded = 1;
      end
      if (m_t % FRAME == 0) begin
        m_disp_val = m_sh_val; m_disp_dp = m_sh_dp;
        if (m_loaded) m_valid = 1;
        m_frames++;
      end
      idx = (m_t / SD) % ND;
      check("seg", seg0, model_seg(0, idx, cur_blink));
      check("seg_lz", seg1, model_seg(1, idx, cur_blink));
      check("digit_en", en0, ~(4'b0001 << idx) & 4'hF);
      check("digit_en_lz", en1, ~(4'b0001 << idx) & 4'hF);
      check("frame_start", fs0, (m_t % FRAME == 0));
      check("frame_start_lz", fs1, (m_t % FRAME == 0));
    end
    load = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, value, dp, 0);
  endtask

  task automatic wait_frame();
    bit got = 0;
    for (int i = 0; i < 4 * FRAME && !got; i++) begin
      step(0, value, dp, 0);
      if (fs0) got = 1;
    end
    check("frame_start_seen", got, 1);
  endtask

  logic [15:0] rv;
  logic [3:0]  rd;
  logic [6:0]  exp26 [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
  logic [7:0]  exp28 [4] = '{8'hC0, 8'hB0, 8'hFF, 8'hFF};

  initial begin
    // Reset, then release: blank until a load reaches a frame boundary.
    step(0, 16'h0, 4'h0, 1);
    step(0, 16'h0, 4'h0, 1);
    step(0, 16'h0, 4'h0, 0);
    check("first_en", en0, 4'b1110);
    check("first_blank", seg0, 8'hFF);
    idle(FRAME + 3);

    // Basic pattern after a load and the following boundary.
    step(1, 16'h12AF, 4'h0, 0);
    wait_frame();
    for (int s = 0; s < ND; s++) begin
      if (s != 0) idle(SD);
      check("pat_12AF", seg0[6:0], exp26[s]);
      check("en_12AF", en0, ~(4'b0001 << s) & 4'hF);
    end

    // Two loads inside one frame: current frame unchanged, last load wins next.
    step(1, 16'h1111, 4'h0, 0);
    step(1, 16'h2222, 4'h0, 0);
    check("no_tear", seg0[6:0], 7'h79);
    wait_frame();
    for (int s = 0; s < ND; s++) begin
      if (s != 0) idle(SD);
      check("last_wins", seg0[6:0], 7'h24);
    end

    // Leading-zero blanking on the second instance.
    step(1, 16'h0030, 4'h0, 0);
    wait_frame();
    for (int s = 0; s < ND; s++) begin
      if (s != 0) idle(SD);
      check("lz_0030", seg1, exp28[s]);
      check("nolz_0030", seg0, (s == 1) ? 8'hB0 : 8'hC0);
    end

    // Load exactly on the boundary edge takes effect this frame.
    idle(SD - 1);
    step(1, 16'h8888, 4'h5, 0);
    check("bypass", seg0, 8'h00);

    // Blink on digit 0.
    cur_blink = 4'b0001;
    step(1, 16'h0005, 4'h0, 0);
    for (int f = 0; f < 6; f++) begin
      wait_frame();
`ifndef HEX_SCAN_BLINK_EN
      check("blink_ignored", seg0, 8'h92);
`endif
    end
    idle(2 * FRAME);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rv = 16'($urandom);
      rd = 4'($urandom);
      cur_blink = 4'($urandom);
      step(($urandom_range(0, 7) == 0), rv, rd, 0);
    end

    // One-edge reset mid-slot, then blank until reloaded.
    idle(SD / 2 + 1);
    step(0, value, dp, 1);
    check("midslot_seg", seg0, 8'hFF);
    check("midslot_en", en0, 4'hF);
    cur_blink = 4'b0000;
    idle(2 * FRAME + 3);
    check("post_rst_blank", seg0, 8'hFF);
    step(1, 16'h0007, 4'h1, 0);
    wait_frame();
    check("post_rst_show", seg0, 8'h78);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
